// File: rtl/reg_file_dump_reader.sv
// reg_file_dump_reader
//   Debug readback engine for the ABC register file. A start pulse in IDLE
//   walks every address 0..2**D-1 through read port B. Each (address, value)
//   pair goes out as one beat on a valid/ready handshake, lowest address first.
//   rf_raddr is driven only in READ, so the port is free whenever the engine
//   is not actively sampling.
//
//   Optional feature macro: DUMP_CHECKSUM_EN
//     When defined, adds csum/csum_valid. csum is the XOR of every accepted
//     beat's data and is presented with the done pulse.
//
// Parameters
//   W  register data width
//   D  register address width (depth 2**D)
//
// Ports
//   clk         system clock, posedge
//   reset_n     asynchronous active-low reset
//   start       dump request, honoured in IDLE only
//   rf_raddr    read address to register file port B
//   rf_rdata    combinational read data from port B
//   out_addr    address of the current beat
//   out_data    register value of the current beat
//   out_valid   beat valid, held until accepted
//   out_ready   sink accept
//   busy        high while a dump is in progress
//   done        one-cycle pulse after the last beat is accepted
//   csum        XOR checksum of the dump       (DUMP_CHECKSUM_EN only)
//   csum_valid  pulses with done                (DUMP_CHECKSUM_EN only)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; read port not driven (address 0)
// READ  | rf_raddr = cnt; snapshot rf_rdata into the beat register
// SEND  | beat presented; wait for handshake
// DONE  | done high for this single cycle, then back to IDLE

module reg_file_dump_reader #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    output logic [D-1:0] rf_raddr,
    input  logic [W-1:0] rf_rdata,
    output logic [D-1:0] out_addr,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [W-1:0] csum,
    output logic         csum_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    localparam logic [D-1:0] LAST_ADDR = '1;

    state_t       state;
    logic [D-1:0] cnt;

    assign rf_raddr = (state == READ) ? cnt : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            out_addr   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum       <= '0;
            csum_valid <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                READ: begin
                    out_data  <= rf_rdata;
                    out_addr  <= cnt;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        csum      <= csum ^ out_data;
`endif
                        // Compare before incrementing so cnt never wraps.
                        if (cnt == LAST_ADDR) begin
                            state      <= DONE;
                            done       <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                            csum_valid <= 1'b1;
`endif
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
